// File: rtl/irq_enc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | irq_enc_pkg : shared constants, FSM states and priority encoder    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package irq_enc_pkg;

  localparam int N_REQ  = 8;
  localparam int CODE_W = 3;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  // Highest set bit wins; an all-zero input encodes to 0.
  function automatic logic [CODE_W-1:0] prio_enc8(input logic [N_REQ-1:0] v);
    logic [CODE_W-1:0] r;
    r = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (v[i]) r = CODE_W'(i);
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_encoder_8_3_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | irq_encoder_8_3_if : request lines and code/valid/ready handshake  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface irq_encoder_8_3_if;
  import irq_enc_pkg::*;

  logic [N_REQ-1:0]  Req;
  logic              Ready;
  logic [CODE_W-1:0] Code;
  logic              Valid;
  logic [N_REQ-1:0]  Pending;
  logic              Overflow;

  modport master (
    output Req,
    output Ready,
    input  Code,
    input  Valid,
    input  Pending,
    input  Overflow
  );

  modport slave (
    input  Req,
    input  Ready,
    output Code,
    output Valid,
    output Pending,
    output Overflow
  );
endinterface
`default_nettype wire

// File: rtl/sync_rise_det.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_rise_det : one-bit synchronizer with rising-edge pulse        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sync_rise_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic i_async,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  // History clears to 0, so a line high across reset release yields one rise.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule
`default_nettype wire

// File: rtl/irq_encoder_8_3.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | irq_encoder_8_3 : registered 8-to-3 priority encoder with pending  |
// | latch and valid/ready output. Rev 1.0                              |
// +--------------------------------------------------------------------+
module irq_encoder_8_3
  import irq_enc_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                Clk,
  input  logic                Reset_n,
  irq_encoder_8_3_if.slave    bus
);

  logic [N_REQ-1:0]  w_rise;
  logic [N_REQ-1:0]  w_clr;
  logic [CODE_W-1:0] w_sel;
  logic              w_any;
  logic              w_load;

  state_t            r_state;
  logic [CODE_W-1:0] r_code;
  logic              r_valid;
  logic [N_REQ-1:0]  r_pending;
  logic              r_overflow;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    sync_rise_det #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_det (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .i_async (bus.Req[gi]),
      .o_rise  (w_rise[gi])
    );
  end

  // Only the registered pending set competes; same-cycle rises wait a cycle.
  assign w_sel  = prio_enc8(r_pending);
  assign w_any  = |r_pending;
  assign w_load = w_any && ((r_state == IDLE) || bus.Ready);
  assign w_clr  = w_load ? (N_REQ'(1) << w_sel) : '0;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= IDLE;
      r_code     <= '0;
      r_valid    <= 1'b0;
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      // Set after clear: a rise on a bit being loaded keeps it pending.
      r_pending  <= (r_pending & ~w_clr) | w_rise;
      r_overflow <= |(w_rise & r_pending & ~w_clr);

      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_code  <= w_sel;
            r_valid <= 1'b1;
            r_state <= PRESENT;
          end
        end
        PRESENT: begin
          if (bus.Ready) begin
            if (w_any) begin
              r_code <= w_sel;
            end else begin
              r_valid <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.Code     = r_code;
  assign bus.Valid    = r_valid;
  assign bus.Pending  = r_pending;
  assign bus.Overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_irq_encoder_8_3.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_irq_encoder_8_3 : directed self-checking bench, 2 and 3 stages  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_irq_encoder_8_3;

  logic Clk;
  logic Reset_n;
  int   checks;
  int   errors;

  irq_encoder_8_3_if bus2 ();
  irq_encoder_8_3_if bus3 ();

  irq_encoder_8_3 #(.SYNC_STAGES(2)) dut2 (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus2.slave)
  );

  irq_encoder_8_3 #(.SYNC_STAGES(3)) dut3 (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus3.slave)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic test_reset;
    Reset_n   = 1'b0;
    bus2.Req  = 8'hFF;
    bus2.Ready = 1'b0;
    bus3.Req  = 8'h00;
    bus3.Ready = 1'b0;
    step(2);
    checks++;
    if (bus2.Code !== 3'd0 || bus2.Valid !== 1'b0 || bus2.Pending !== 8'h00 || bus2.Overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: code=%0d valid=%b pend=%h ovf=%b, want all 0",
               bus2.Code, bus2.Valid, bus2.Pending, bus2.Overflow);
    end
    checks++;
    if (bus3.Valid !== 1'b0 || bus3.Pending !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs3: valid=%b pend=%h, want 0", bus3.Valid, bus3.Pending);
    end
    Reset_n = 1'b1;
    step(2);
    checks++;
    if (bus2.Pending !== 8'h00) begin
      errors++;
      $display("FAIL reset_pend_early: pend=%h want 00", bus2.Pending);
    end
    step(1);
    checks++;
    if (bus2.Pending !== 8'hFF || bus2.Valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_pend_ff: pend=%h valid=%b want ff 0", bus2.Pending, bus2.Valid);
    end
    step(1);
    checks++;
    if (bus2.Code !== 3'd7 || bus2.Valid !== 1'b1 || bus2.Pending !== 8'h7F) begin
      errors++;
      $display("FAIL reset_first_code: code=%0d valid=%b pend=%h want 7 1 7f",
               bus2.Code, bus2.Valid, bus2.Pending);
    end
    bus2.Ready = 1'b1;
    for (int i = 6; i >= 0; i--) begin
      step(1);
      checks++;
      if (bus2.Code !== 3'(i) || bus2.Valid !== 1'b1) begin
        errors++;
        $display("FAIL reset_drain: code=%0d valid=%b want %0d 1", bus2.Code, bus2.Valid, i);
      end
    end
    step(1);
    checks++;
    if (bus2.Valid !== 1'b0 || bus2.Code !== 3'd0) begin
      errors++;
      $display("FAIL reset_drain_end: valid=%b code=%0d want 0 0", bus2.Valid, bus2.Code);
    end
    bus2.Ready = 1'b0;
    bus2.Req   = 8'h00;
    step(4);
  endtask

  task automatic test_single;
    bus2.Req = 8'h20;
    for (int n = 1; n <= 3; n++) begin
      step(1);
      if (n == 2) bus2.Req = 8'h00;
      checks++;
      if (bus2.Valid !== 1'b0) begin
        errors++;
        $display("FAIL single_early_valid: cycle=%0d valid=%b want 0", n, bus2.Valid);
      end
    end
    checks++;
    if (bus2.Pending !== 8'h20) begin
      errors++;
      $display("FAIL single_pending: pend=%h want 20", bus2.Pending);
    end
    for (int n = 4; n <= 5; n++) begin
      step(1);
      checks++;
      if (bus2.Valid !== 1'b1 || bus2.Code !== 3'd5 || bus2.Pending !== 8'h00) begin
        errors++;
        $display("FAIL single_code: cycle=%0d code=%0d valid=%b pend=%h want 5 1 00",
                 n, bus2.Code, bus2.Valid, bus2.Pending);
      end
    end
    bus2.Ready = 1'b1;
    step(1);
    bus2.Ready = 1'b0;
    checks++;
    if (bus2.Valid !== 1'b0 || bus2.Code !== 3'd5) begin
      errors++;
      $display("FAIL single_accept: valid=%b code=%0d want 0 5", bus2.Valid, bus2.Code);
    end
    step(3);
  endtask

  task automatic test_back_to_back;
    logic [2:0] exp_code [4];
    exp_code[0] = 3'd7; exp_code[1] = 3'd5; exp_code[2] = 3'd2; exp_code[3] = 3'd1;
    bus2.Ready = 1'b1;
    bus2.Req   = 8'b1010_0110;
    step(2);
    bus2.Req = 8'h00;
    step(1);
    checks++;
    if (bus2.Pending !== 8'hA6 || bus2.Valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_pending: pend=%h valid=%b want a6 0", bus2.Pending, bus2.Valid);
    end
    for (int i = 0; i < 4; i++) begin
      step(1);
      checks++;
      if (bus2.Code !== exp_code[i] || bus2.Valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_code: idx=%0d code=%0d valid=%b want %0d 1",
                 i, bus2.Code, bus2.Valid, exp_code[i]);
      end
    end
    step(1);
    checks++;
    if (bus2.Valid !== 1'b0 || bus2.Code !== 3'd1 || bus2.Pending !== 8'h00) begin
      errors++;
      $display("FAIL b2b_end: valid=%b code=%0d pend=%h want 0 1 00",
               bus2.Valid, bus2.Code, bus2.Pending);
    end
    bus2.Ready = 1'b0;
    step(3);
  endtask

  task automatic test_overflow_setwins;
    bus2.Req = 8'h0A;
    step(2);
    bus2.Req = 8'h00;
    step(2);
    checks++;
    if (bus2.Code !== 3'd3 || bus2.Valid !== 1'b1 || bus2.Pending !== 8'h02) begin
      errors++;
      $display("FAIL ovf_setup: code=%0d valid=%b pend=%h want 3 1 02",
               bus2.Code, bus2.Valid, bus2.Pending);
    end
    step(1);
    bus2.Req = 8'h02;
    for (int n = 1; n <= 4; n++) begin
      step(1);
      if (n == 2) bus2.Req = 8'h00;
      checks++;
      if (bus2.Overflow !== (n == 3) || bus2.Pending !== 8'h02 || bus2.Code !== 3'd3) begin
        errors++;
        $display("FAIL ovf_pulse: cycle=%0d ovf=%b pend=%h code=%0d want %b 02 3",
                 n, bus2.Overflow, bus2.Pending, bus2.Code, (n == 3));
      end
    end
    step(2);
    bus2.Req = 8'h02;
    step(2);
    bus2.Req   = 8'h00;
    bus2.Ready = 1'b1;
    step(1);
    bus2.Ready = 1'b0;
    checks++;
    if (bus2.Code !== 3'd1 || bus2.Valid !== 1'b1 || bus2.Pending !== 8'h02 || bus2.Overflow !== 1'b0) begin
      errors++;
      $display("FAIL setwins_load: code=%0d valid=%b pend=%h ovf=%b want 1 1 02 0",
               bus2.Code, bus2.Valid, bus2.Pending, bus2.Overflow);
    end
    step(1);
    checks++;
    if (bus2.Overflow !== 1'b0 || bus2.Pending !== 8'h02) begin
      errors++;
      $display("FAIL setwins_hold: ovf=%b pend=%h want 0 02", bus2.Overflow, bus2.Pending);
    end
    bus2.Ready = 1'b1;
    step(1);
    checks++;
    if (bus2.Code !== 3'd1 || bus2.Valid !== 1'b1 || bus2.Pending !== 8'h00) begin
      errors++;
      $display("FAIL setwins_reserve: code=%0d valid=%b pend=%h want 1 1 00",
               bus2.Code, bus2.Valid, bus2.Pending);
    end
    step(1);
    checks++;
    if (bus2.Valid !== 1'b0) begin
      errors++;
      $display("FAIL setwins_idle: valid=%b want 0", bus2.Valid);
    end
    bus2.Ready = 1'b0;
    step(3);
  endtask

  task automatic test_reset_mid;
    bus2.Req = 8'h1C;
    step(2);
    bus2.Req = 8'h00;
    step(2);
    checks++;
    if (bus2.Code !== 3'd4 || bus2.Valid !== 1'b1 || bus2.Pending !== 8'h0C) begin
      errors++;
      $display("FAIL mid_setup: code=%0d valid=%b pend=%h want 4 1 0c",
               bus2.Code, bus2.Valid, bus2.Pending);
    end
    #2;
    Reset_n = 1'b0;
    #1;
    checks++;
    if (bus2.Code !== 3'd0 || bus2.Valid !== 1'b0 || bus2.Pending !== 8'h00 || bus2.Overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_async_clear: code=%0d valid=%b pend=%h ovf=%b want all 0",
               bus2.Code, bus2.Valid, bus2.Pending, bus2.Overflow);
    end
    step(2);
    Reset_n = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      step(1);
      checks++;
      if (bus2.Valid !== 1'b0 || bus2.Pending !== 8'h00) begin
        errors++;
        $display("FAIL mid_after_release: cycle=%0d valid=%b pend=%h want 0 00",
                 n, bus2.Valid, bus2.Pending);
      end
    end
  endtask

  task automatic test_sync3;
    bus3.Req = 8'h20;
    for (int n = 1; n <= 4; n++) begin
      step(1);
      if (n == 2) bus3.Req = 8'h00;
      checks++;
      if (bus3.Valid !== 1'b0) begin
        errors++;
        $display("FAIL sync3_early_valid: cycle=%0d valid=%b want 0", n, bus3.Valid);
      end
    end
    checks++;
    if (bus3.Pending !== 8'h20) begin
      errors++;
      $display("FAIL sync3_pending: pend=%h want 20", bus3.Pending);
    end
    step(1);
    checks++;
    if (bus3.Valid !== 1'b1 || bus3.Code !== 3'd5) begin
      errors++;
      $display("FAIL sync3_code: code=%0d valid=%b want 5 1", bus3.Code, bus3.Valid);
    end
    bus3.Ready = 1'b1;
    step(1);
    bus3.Ready = 1'b0;
    checks++;
    if (bus3.Valid !== 1'b0) begin
      errors++;
      $display("FAIL sync3_accept: valid=%b want 0", bus3.Valid);
    end
    step(2);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow_setwins();
    test_reset_mid();
    test_sync3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
